// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {instruction, pc} pairs; flush wins over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [INST_W-1:0] push_inst,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic              pop,
  input  logic              flush,
  output logic [PTR_W:0]    count,
  output logic [INST_W-1:0] head_inst,
  output logic [ADDR_W-1:0] head_pc
);

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_pop;

  assign do_pop = pop && (count != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) begin
        inst_mem[wr_ptr] <= push_inst;
        pc_mem[wr_ptr]   <= push_pc;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !do_pop) begin
        count <= count + (PTR_W+1)'(1);
      end else if (!push && do_pop) begin
        count <= count - (PTR_W+1)'(1);
      end
    end
  end

  assign head_inst = inst_mem[rd_ptr];
  assign head_pc   = pc_mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the fetch PC, issues word reads over req/ack and
// feeds decode from a prefetch FIFO, flushing on branch/jump redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pc_next;
  logic [PTR_W:0]    count;
  logic [PTR_W:0]    count_after;
  logic              push;
  logic              pop;

  assign push        = (state == WAIT) && mem_ack && !redirect;
  assign pop         = inst_valid && inst_ready;
  assign count_after = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  assign mem_req     = (state != IDLE);
  assign inst_valid  = (count != '0);

  // A new request is only started when the FIFO has room for its reply,
  // so a push can never land on a full FIFO.
  always_comb begin
    state_next = state;
    pc_next    = fetch_pc;
    case (state)
      IDLE: begin
        if (!redirect && (count < (PTR_W+1)'(DEPTH))) state_next = WAIT;
      end
      WAIT: begin
        if (redirect) state_next = mem_ack ? IDLE : DROP;
        else if (mem_ack) state_next = (count_after < (PTR_W+1)'(DEPTH)) ? WAIT : IDLE;
      end
      DROP: begin
        if (mem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (redirect) pc_next = redirect_pc & ~ADDR_W'(3);
    else if (push) pc_next = fetch_pc + ADDR_W'(PC_STEP);
  end

  // mem_addr is frozen while a request is pending so the handshake completes
  // at the address that was issued, even after a redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      mem_addr <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= pc_next;
      if ((state == IDLE) || mem_ack) mem_addr <= pc_next;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_inst(mem_rdata),
    .push_pc  (fetch_pc),
    .pop      (pop),
    .flush    (redirect),
    .count    (count),
    .head_inst(inst),
    .head_pc  (inst_pc)
  );

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end that sits directly upstream of the single-cycle datapath.
- Owns the fetch PC and issues word reads to a variable-latency instruction memory over a req/ack handshake.
- Buffers returned instructions in a small prefetch FIFO and presents them to decode with a valid/ready handshake.
- Accepts branch/jump redirects from the datapath, flushing buffered and in-flight instructions.

Parameters:
DEPTH, 4, prefetch FIFO entries (power of two, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset
ADDR_W, 32, PC/address width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
mem_req  out  1  instruction read request, held until mem_ack
mem_addr  out  ADDR_W  word address of request, stable while mem_req=1
mem_ack  in  1  one-cycle pulse, mem_rdata valid this cycle
mem_rdata  in  32  returned instruction word
redirect  in  1  branch/jump taken, one-cycle pulse
redirect_pc  in  ADDR_W  new fetch target
inst_valid  out  1  FIFO head valid
inst  out  32  FIFO head instruction
inst_pc  out  ADDR_W  PC of FIFO head
inst_ready  in  1  decode consumes head when inst_valid & inst_ready

Behaviour:
- Reset (rst=0, async): state=IDLE, fetch_pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, FIFO empty, inst_valid=0, inst=0, inst_pc=0, all storage cleared.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, data will be kept.
  - DROP: request outstanding, data will be discarded.
- mem_req=1 exactly in WAIT and DROP. mem_addr=fetch_pc, registered.
- IDLE->WAIT when count+0 < DEPTH and no redirect this cycle. mem_req rises the next edge, so reset release gives req one cycle later.
- WAIT, mem_ack=1, no redirect:
  - Push {mem_rdata, fetch_pc}; fetch_pc += 4.
  - Go to WAIT if (count after push/pop) < DEPTH, else IDLE. Back-to-back requests give 1 instruction/cycle when ack is immediate.
- mem_ack may assert in the first cycle mem_req is high; zero extra latency is required.
- Space is reserved for the outstanding request, so a push never finds the FIFO full. Push and pop in the same cycle are allowed; count is unchanged.
- inst_valid = (count != 0). inst/inst_pc = head entry, combinational from storage. A pushed entry becomes visible the cycle after ack.
- Redirect, any state:
  - FIFO flushed (count=0) at the edge; any same-cycle pop is ignored.
  - fetch_pc = {redirect_pc[ADDR_W-1:2], 2'b00}; misaligned low bits are forced to zero.
- Redirect in IDLE: stay IDLE one cycle, then the normal request rule applies.
- Redirect in WAIT without ack: go to DROP. mem_req stays 1 and mem_addr stays at the old address until ack, because the handshake is never abandoned.
- Redirect in WAIT with same-cycle ack: data discarded, go to IDLE, fetch_pc = new target.
- DROP, mem_ack=1: discard data, go to IDLE. fetch_pc is the redirect target, already loaded.
- Redirect in DROP: update fetch_pc and stay in DROP. With a same-cycle ack, go to IDLE with the newest target.
- mem_ack in IDLE is a protocol error and is ignored.
- fetch_pc wraps modulo 2^ADDR_W at the top of the address space.
- Pointers are log2(DEPTH) bits with natural wrap. count is log2(DEPTH)+1 bits.

Decomposition:
- Package fetch_pkg: FSM state encoding (IDLE/WAIT/DROP), INST_W=32, PC_STEP=4.
- One sub-module, fetch_fifo: DEPTH-entry FIFO of {inst, pc} with push, pop, flush and count. Flush has priority over push and pop.
- The FSM and PC logic live in fetch_unit.

Test Plan:
1. Reset and immediate-ack stream:
   - Stimulus: rst low then high; mem_ack tied to mem_req, rdata=addr^32'hA5A5_0000; inst_ready=1.
   - Response: first mem_req one cycle after release at 0x0; thereafter one instruction per cycle with inst_pc 0,4,8,…, inst=pc^A5A50000.
2. Backpressure:
   - Stimulus: inst_ready=0, immediate ack.
   - Response: exactly DEPTH=4 entries (pc 0..0xC), then mem_req=0 and inst_valid=1 steady. One ready pulse yields pc 0 and exactly one new request at 0x10.
3. Redirect while waiting:
   - Stimulus: ack latency 3; redirect to 0x100 one cycle after req for 0x8.
   - Response: mem_req held at 0x8 until ack, data dropped, FIFO empty; next request to 0x100; inst_pc 0x100 is the next valid.
4. Redirect with same-cycle ack:
   - Stimulus: redirect to 0x200 in the same cycle as ack for 0x4.
   - Response: 0x4 never appears on inst; next mem_addr is 0x200.
5. Misaligned redirect and wrap:
   - Stimulus: redirect_pc=0x0000_0203.
   - Response: fetch at 0x200.
   - Stimulus: RESET_PC=32'hFFFF_FFFC.
   - Response: second fetch at 0x0.
6. Reset mid-operation:
   - Stimulus: rst low asynchronously while in WAIT with 2 entries buffered.
   - Response: mem_req=0 and inst_valid=0 immediately, without waiting for an edge. After release, fetch restarts at RESET_PC.
